// File: rtl/key_scan.sv
// Key matrix scanner: strobes 4 active-low columns, reads 8 active-low rows,
// debounces all 32 keys and reports press/release events over valid/ready.
module key_scan #(
  parameter int SCAN_DIV = 4096,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  kcol,
  input  logic [7:0]  krow,
  output logic [31:0] keys,
  output logic        event_valid,
  input  logic        event_ready,
  output logic [4:0]  event_code,
  output logic        event_press
);

  localparam int DW = $clog2(SCAN_DIV) + 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 2);
  localparam logic [3:0] DB = 4'(DEBOUNCE);

  typedef enum logic [1:0] {BLANK, DRIVE, SAMPLE} state_t;

  state_t        state, state_next;
  logic [1:0]    col;
  logic [DW-1:0] dwell;
  logic [7:0]    krow_s1, krow_s2;
  logic [7:0]    sync_row;
  logic [3:0]    cnt [32];
  logic [3:0]    row_cnt_next [8];
  logic [2:0]    pick_row;
  logic          pick_valid;
  logic          commit;

  // Rows are asynchronous to clk; idle (no key) reads as all ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      krow_s1 <= 8'hFF;
      krow_s2 <= 8'hFF;
    end else begin
      krow_s1 <= krow;
      krow_s2 <= krow_s1;
    end
  end

  assign sync_row = ~krow_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BLANK;
      col   <= '0;
      dwell <= '0;
    end else begin
      state <= state_next;
      case (state)
        BLANK:   dwell <= '0;
        DRIVE:   dwell <= dwell + 1'b1;
        SAMPLE:  col   <= col + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    kcol       = 4'b1111;
    case (state)
      BLANK: state_next = DRIVE;
      DRIVE: begin
        kcol = ~(4'b0001 << col);
        if (dwell == DWELL_LAST) state_next = SAMPLE;
      end
      SAMPLE: begin
        kcol       = ~(4'b0001 << col);
        state_next = BLANK;
      end
      default: state_next = BLANK;
    endcase
  end

  // Next counter value for each row of the current column; the lowest row
  // whose updated counter reaches DEBOUNCE is the commit candidate.
  always_comb begin
    pick_row   = '0;
    pick_valid = 1'b0;
    for (int r = 0; r < 8; r++) begin
      row_cnt_next[r] = '0;
      if (sync_row[r] != keys[{col, 3'(r)}]) begin
        row_cnt_next[r] = (cnt[{col, 3'(r)}] >= DB) ? DB : cnt[{col, 3'(r)}] + 4'd1;
      end
      if (!pick_valid && row_cnt_next[r] == DB) begin
        pick_valid = 1'b1;
        pick_row   = 3'(r);
      end
    end
  end

  assign commit = (state == SAMPLE) && pick_valid && (!event_valid || event_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      keys        <= '0;
      event_valid <= 1'b0;
      event_code  <= '0;
      event_press <= 1'b0;
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
    end else begin
      if (state == SAMPLE) begin
        for (int r = 0; r < 8; r++) cnt[{col, 3'(r)}] <= row_cnt_next[r];
      end
      if (commit) begin
        cnt[{col, pick_row}]  <= '0;
        keys[{col, pick_row}] <= ~keys[{col, pick_row}];
        event_code            <= {col, pick_row};
        event_press           <= ~keys[{col, pick_row}];
        event_valid           <= 1'b1;
      end else if (event_ready) begin
        event_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: a physical 4x8 matrix driven by a pressed-key map, and a
// cycle-count based reference of the scan, debounce and event rules.
module tb_key_scan;

  localparam int SCAN_DIV    = 8;
  localparam int DEBOUNCE    = 3;
  localparam int COL_PERIOD  = SCAN_DIV + 1;
  localparam int SCAN_PERIOD = 4 * COL_PERIOD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  kcol;
  logic [7:0]  krow;
  logic [31:0] keys;
  logic        event_valid;
  logic        event_ready;
  logic [4:0]  event_code;
  logic        event_press;

  logic [31:0] pressed;
  logic        krow_zero;

  int          w;
  logic [31:0] m_keys;
  int          m_cnt [32];
  logic        m_valid;
  logic [4:0]  m_code;
  logic        m_press;

  int num_compared   = 0;
  int num_mismatched = 0;

  always #5 clk = ~clk;

  key_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .kcol        (kcol),
    .krow        (krow),
    .keys        (keys),
    .event_valid (event_valid),
    .event_ready (event_ready),
    .event_code  (event_code),
    .event_press (event_press)
  );

  // Passive matrix: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    krow = 8'hFF;
    if (krow_zero) krow = 8'h00;
    else begin
      for (int c = 0; c < 4; c++)
        if (!kcol[c]) krow = krow & ~pressed[c*8 +: 8];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_compared++;
    if (got !== exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    w       = 0;
    m_keys  = '0;
    m_valid = 1'b0;
    m_code  = '0;
    m_press = 1'b0;
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
  endtask

  // w counts cycles since reset; each column gets one blank cycle then SCAN_DIV
  // strobed cycles, and its rows are judged at the end of the last one.
  task automatic model_step();
    int   c;
    int   pick;
    int   idx;
    logic committed;
    committed = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (w % COL_PERIOD == COL_PERIOD - 1) begin
        c    = (w / COL_PERIOD) % 4;
        pick = -1;
        for (int r = 0; r < 8; r++) begin
          idx = c * 8 + r;
          if (pressed[idx] == m_keys[idx]) m_cnt[idx] = 0;
          else if (m_cnt[idx] < DEBOUNCE) m_cnt[idx] = m_cnt[idx] + 1;
          if (pick < 0 && m_cnt[idx] == DEBOUNCE) pick = r;
        end
        if (pick >= 0 && (!m_valid || event_ready)) begin
          idx          = c * 8 + pick;
          m_keys[idx]  = ~m_keys[idx];
          m_cnt[idx]   = 0;
          m_code       = 5'(idx);
          m_press      = m_keys[idx];
          m_valid      = 1'b1;
          committed    = 1'b1;
        end
      end
      if (!committed && m_valid && event_ready) m_valid = 1'b0;
      w++;
    end
  endtask

  function automatic logic [3:0] exp_kcol();
    if (w % COL_PERIOD == 0) return 4'hF;
    return ~(4'b0001 << ((w / COL_PERIOD) % 4));
  endfunction

  task automatic applyStimulus(input logic rst_val, input logic rdy_val);
    @(negedge clk);
    rst_n       = rst_val;
    event_ready = rdy_val;
    @(posedge clk);
    model_step();
    #1;
    checkOutput("kcol", 32'(kcol), 32'(exp_kcol()));
    checkOutput("keys", keys, m_keys);
    checkOutput("event_valid", 32'(event_valid), 32'(m_valid));
    checkOutput("event_code", 32'(event_code), 32'(m_code));
    checkOutput("event_press", 32'(event_press), 32'(m_press));
  endtask

  // mode: 0 ready low, 1 ready high, 2 random ready, 3 one ready pulse mid-scan
  task automatic run_scans(input logic [31:0] held, input int n, input int mode);
    logic rdy;
    while (w % SCAN_PERIOD != 0) applyStimulus(1'b1, 1'b1);
    for (int s = 0; s < n; s++) begin
      pressed = held;
      for (int k = 0; k < SCAN_PERIOD; k++) begin
        case (mode)
          0:       rdy = 1'b0;
          1:       rdy = 1'b1;
          2:       rdy = 1'($urandom % 2);
          default: rdy = (k == 20);
        endcase
        applyStimulus(1'b1, rdy);
      end
    end
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] mask;
    rst_n       = 1'b0;
    event_ready = 1'b0;
    pressed     = '0;
    krow_zero   = 1'b1;
    model_reset();

    $display("[TB] reset with rows forced low");
    repeat (5) applyStimulus(1'b0, 1'b0);
    krow_zero = 1'b0;

    $display("[TB] single press and release of key 21");
    run_scans(32'h1 << 21, 4, 1);
    run_scans('0, 4, 1);

    $display("[TB] bounce on key 0");
    run_scans(32'h1, 2, 1);
    run_scans('0, 1, 1);
    run_scans(32'h1, 3, 1);
    run_scans('0, 4, 1);

    $display("[TB] two keys in column 3");
    run_scans((32'h1 << 25) | (32'h1 << 30), 5, 1);
    run_scans('0, 5, 1);

    $display("[TB] backpressure on keys 8 and 9");
    run_scans(32'h300, 6, 0);
    run_scans(32'h300, 1, 3);
    run_scans(32'h300, 2, 1);
    run_scans('0, 5, 1);

    $display("[TB] random keys and ready");
    held = '0;
    for (int s = 0; s < 40; s++) begin
      mask = '0;
      for (int i = 0; i < 32; i++) if ($urandom_range(0, 11) == 0) mask[i] = 1'b1;
      held = held ^ mask;
      run_scans(held, 1, 2);
    end
    run_scans('0, 10, 1);

    $display("[TB] reset while an event is pending");
    run_scans(32'h1 << 21, 4, 0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    run_scans(32'h1 << 21, 5, 1);
    run_scans('0, 5, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule

// File: doc/key_scan.md
Name: key_scan

Overview:
- Input-side counterpart of the LED matrix scan path. Drives a 4-column strobe into an external 4x8 key or switch matrix and reads the 8 row lines.
- Debounces each of the 32 keys and presents two outputs:
  - a debounced key-state map, laid out like the LED holding registers (column n maps to byte n);
  - press/release events through a valid/ready handshake.
- Sits at top level beside the LED scan logic and feeds user logic.

Parameters:
- SCAN_DIV, 4096: clock cycles each column is driven (dwell). Must be >= 4.
- DEBOUNCE, 4: consecutive identical samples of a key required to commit a change. Range 1..15.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- rst_n, input, 1: synchronous reset, active-low.
- kcol, output, 4: column strobes, active-low; at most one bit low at any time.
- krow, input, 8: row returns, active-low (external pull-ups), asynchronous to clk.
- keys, output, 32: debounced state, 1 = pressed; bit index = col*8 + row.
- event_valid, output, 1: event pending.
- event_ready, input, 1: consumer accepts event.
- event_code, output, 5: col*8 + row of the event key.
- event_press, output, 1: 1 = press, 0 = release.

Behaviour:
- **Reset** (rst_n low at a posedge):
  - kcol = 4'b1111; keys = 0; event_valid = 0; event_code = 0; event_press = 0.
  - Column index = 0; dwell counter = 0; all debounce counters = 0; synchronizer flops = 8'hFF.
  - Reset mid-scan or mid-event discards all pending state; nothing is held over.
- **Synchronizer:** krow passes through 2 flops. sync_row = ~krow_sync2 (1 = pressed).
- **Scan FSM**, states BLANK → DRIVE → SAMPLE → BLANK:
  - BLANK: 1 cycle, kcol = 4'b1111 (anti-ghost gap). Next state DRIVE, dwell counter cleared.
  - DRIVE: kcol[col] = 0, others 1. Dwell counter increments. At dwell == SCAN_DIV-2, go to SAMPLE.
  - SAMPLE: 1 cycle, kcol still driven. sync_row is captured for the current column. col = (col+1) mod 4, wrapping 3→0. Next state BLANK.
  - Column period = SCAN_DIV+1 cycles; full scan = 4*(SCAN_DIV+1).
  - The first column 0 drive begins on the 2nd cycle after reset release.
- **Debounce**, per key, 4-bit counter, evaluated only in SAMPLE for the 8 keys of the current column:
  - Sample equals keys[bit]: counter ← 0.
  - Sample differs: counter ← min(counter+1, DEBOUNCE).
  - A key is "ripe" when its counter == DEBOUNCE.
- **Commit**, in SAMPLE, only when event_valid = 0, or when event_valid = 1 and event_ready = 1 in that same cycle:
  - Pick the lowest-row ripe key in the column.
  - Toggle its keys bit; clear its counter.
  - Load event_code = col*8 + row and event_press = new keys bit; set event_valid = 1 on the next cycle.
- **Limits and blocking:**
  - At most one commit per SAMPLE. Other ripe keys stay saturated and commit on later scans, lowest row first.
  - While event_valid = 1 and event_ready = 0, no commits occur; keys and counters keep saturating. No event is ever lost and no overflow exists.
- **Handshake:**
  - event_valid, event_code and event_press hold stable until event_valid & event_ready at a posedge. event_valid then drops unless a commit occurs in that same cycle.
  - event_ready while event_valid = 0 is ignored.
- **Bounce:** a sample equal to the committed state resets the counter, so a key must read differing for DEBOUNCE consecutive scans of its column before it commits.
- **Simultaneous events:** ready-accept and a new commit in the same cycle produce back-to-back events with event_valid staying high.

Test Plan (SCAN_DIV=8, DEBOUNCE=3; scan period 36 cycles):
- **Reset:** hold rst_n = 0 for 5 cycles with krow = 8'h00 → kcol = 4'hF, keys = 0, event_valid = 0 throughout. After release, kcol sequence is 1110,1111,1101,1111,1011,1111,0111,1111 with 8-cycle lows and 1-cycle highs.
- **Press:** krow[5] low only while kcol[2] = 0, event_ready = 1 → on the 3rd column-2 SAMPLE: keys[21] = 1, event_valid pulses 1 cycle, event_code = 21, event_press = 1. Release the key → 3 scans later event_code = 21, event_press = 0, keys[21] = 0.
- **Bounce:** key (col 0, row 0) pressed 2 scans, released 1 scan, pressed 2 scans → no event, keys[0] = 0; held a 3rd consecutive scan → press event, code 0.
- **Multi-key:** rows 1 and 6 of col 3 pressed together → event code 25 first, code 30 exactly one scan later; keys[25] = keys[30] = 1.
- **Backpressure:** event_ready = 0 while keys 8 and 9 press → single event code 8 held stable, keys[9] stays 0. Raise event_ready for 1 cycle → code 8 accepted; code 9 appears at the next column-1 SAMPLE.
- **Reset mid-operation:** assert rst_n = 0 while event_valid = 1 with keys[21] = 1 → next cycle keys = 0, event_valid = 0, kcol = 4'hF. If the key is still held after release, the press event re-emerges after 3 scans.
